// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions: transmitter FSM state type, default oversample
//   ratio and the character-format configuration struct (also used by the
//   receiver side).
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Character format, captured once per frame.
   typedef struct packed {
      logic data7;       // 1 = 7 data bits
      logic parity_en;   // insert parity bit
      logic parity_odd;  // 1 = odd parity
      logic stop2;       // 1 = two stop bits
   } uart_cfg_t;

endpackage

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   Serialises bytes popped from the TX FIFO onto txd, timed by the
//   oversampled b_tick strobe. Frame: start, 7/8 data bits LSB first,
//   optional even/odd parity, 1/2 stop bits.
//
// Ports
//   clk        in   system clock
//   a_reset    in   asynchronous active-high reset
//   b_tick     in   baud strobe, OVERSAMPLE pulses per bit
//   tx_data    in   character to send (bit 0 first)
//   tx_valid   in   FIFO not empty
//   tx_ready   out  transmitter idle; acts as FIFO pop
//   data7      in   1 = 7 data bits
//   parity_en  in   insert parity bit
//   parity_odd in   1 = odd parity
//   stop2      in   1 = two stop bits
//   txd        out  serial line, idle high, registered
//   tx_busy    out  frame in progress
//   tx_done    out  one-cycle pulse at end of last stop bit
// ----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clk,
   input  logic       a_reset,
   input  logic       b_tick,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       data7,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       stop2,
   output logic       txd,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   tx_state_t       r_state;
   logic [TW-1:0]   r_tick_cnt;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic            r_parity;
   uart_cfg_t       r_cfg;
   logic            r_txd;
   logic            r_done;

   logic            w_bit_end;
   logic            w_last_data;

   assign w_bit_end   = b_tick && (r_tick_cnt == TICK_LAST);
   assign w_last_data = (r_bit_cnt == (r_cfg.data7 ? 3'd6 : 3'd7));

   assign tx_ready = (r_state == IDLE);
   assign tx_busy  = (r_state != IDLE);
   assign txd      = r_txd;
   assign tx_done  = r_done;

   // txd is registered, so each state computes the level of the *next* bit
   // at the bit boundary. The shift register and running parity are
   // advanced as each data bit is driven, so parity covers only sent bits.
   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_cfg      <= '0;
         r_txd      <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (tx_valid) begin
               r_shift          <= tx_data;
               r_cfg.data7      <= data7;
               r_cfg.parity_en  <= parity_en;
               r_cfg.parity_odd <= parity_odd;
               r_cfg.stop2      <= stop2;
               r_tick_cnt       <= '0;
               r_bit_cnt        <= '0;
               r_parity         <= 1'b0;
               r_txd            <= 1'b0;
               r_state          <= START;
            end
         end else if (b_tick) begin
            r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            if (w_bit_end) begin
               case (r_state)
                  START: begin
                     r_txd     <= r_shift[0];
                     r_parity  <= r_parity ^ r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_bit_cnt <= '0;
                     r_state   <= DATA;
                  end
                  DATA: begin
                     if (w_last_data) begin
                        r_bit_cnt <= '0;
                        if (r_cfg.parity_en) begin
                           r_txd   <= r_parity ^ r_cfg.parity_odd;
                           r_state <= PARITY;
                        end else begin
                           r_txd   <= 1'b1;
                           r_state <= STOP;
                        end
                     end else begin
                        r_txd     <= r_shift[0];
                        r_parity  <= r_parity ^ r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                     end
                  end
                  PARITY: begin
                     r_txd     <= 1'b1;
                     r_bit_cnt <= '0;
                     r_state   <= STOP;
                  end
                  STOP: begin
                     // bit counter reused to count the second stop bit
                     if (r_cfg.stop2 && (r_bit_cnt == 3'd0)) begin
                        r_bit_cnt <= 3'd1;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                     end
                  end
                  default: begin
                     r_txd   <= 1'b1;
                     r_state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//   Scoreboard bench for uart_tx. Stimulus pushes the hand-computed frame
//   (bit k = k-th bit on the line, start bit at k=0) when a byte is accepted;
//   the monitor decodes txd from each falling edge and compares.
//   b_tick every 4 clocks, OVERSAMPLE = 16 -> 64 clocks per bit.
// ----------------------------------------------------------------------------
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       a_reset = 1'b1;
   logic       b_tick = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       data7 = 1'b0;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       stop2 = 1'b0;
   logic       txd;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] bits;
      int          len;
      bit          abort;
   } exp_t;

   exp_t q[$];

   int  accepts = 0;
   int  last_gap = -1;
   bit  mon_busy = 1'b0;
   int  tdiv = 0;

   uart_tx #(.OVERSAMPLE(16)) dut (
      .clk        (clk),
      .a_reset    (a_reset),
      .b_tick     (b_tick),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .data7      (data7),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tdiv = (tdiv + 1) % 4;
      b_tick = (tdiv == 0);
   end

   always @(posedge clk) begin
      if (!a_reset && tx_valid && tx_ready) accepts = accepts + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      logic        prev_txd;
      int          since_done;
      exp_t        e;
      logic [11:0] got;
      int          off;
      bit          aborted;
      prev_txd   = 1'b1;
      since_done = 100000;
      forever begin
         @(negedge clk);
         since_done = since_done + 1;
         if (!a_reset && prev_txd === 1'b1 && txd === 1'b0) begin
            mon_busy = 1'b1;
            last_gap = since_done;
            if (q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               off = 0;
               while (txd !== 1'b1 && off < 2000) begin
                  @(negedge clk);
                  off = off + 1;
               end
            end else begin
               e = q.pop_front();
               got = '0;
               off = 0;
               aborted = 1'b0;
               for (int k = 0; k < e.len && !aborted; k++) begin
                  while (off < 32 + 64 * k && !aborted) begin
                     @(negedge clk);
                     off = off + 1;
                     if (a_reset) aborted = 1'b1;
                  end
                  if (!aborted) got[k] = txd;
               end
               if (aborted || e.abort) begin
                  check("frame_abort", 32'(aborted), 32'(e.abort));
               end else begin
                  check("frame_bits", 32'(got), 32'(e.bits));
                  while (tx_done !== 1'b1 && off < 64 * e.len + 8) begin
                     @(negedge clk);
                     off = off + 1;
                  end
                  check("done_seen", 32'(tx_done), 1);
                  check("done_timing",
                        32'((off >= 64 * e.len - 3) && (off <= 64 * e.len)), 1);
                  since_done = 0;
               end
            end
            mon_busy = 1'b0;
         end
         prev_txd = txd;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic wait_ready();
      int n = 0;
      while (tx_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n = n + 1;
      end
      if (tx_ready !== 1'b1) check("ready_timeout", 32'(tx_ready), 1);
   endtask

   // cfg = {data7, parity_en, parity_odd, stop2}
   task automatic send(input logic [7:0] d, input logic [3:0] cfg,
                       input logic [11:0] bits, input int len, input bit abort);
      exp_t e;
      @(negedge clk);
      tx_data    = d;
      data7      = cfg[3];
      parity_en  = cfg[2];
      parity_odd = cfg[1];
      stop2      = cfg[0];
      tx_valid   = 1'b1;
      wait_ready();
      @(posedge clk);
      e.bits = bits; e.len = len; e.abort = abort;
      q.push_back(e);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (4) @(negedge clk);
      while ((tx_busy !== 1'b0 || mon_busy || q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n = n + 1;
      end
      check("idle_timeout", 32'(n < 3000), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin : stimulus
      int   acc0;
      exp_t e;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 1);
      check("rst_busy", 32'(tx_busy), 0);
      check("rst_ready", 32'(tx_ready), 1);
      check("rst_done", 32'(tx_done), 0);
      a_reset = 1'b0;
      repeat (5) @(negedge clk);

      // 8N1 0x55
      send(8'h55, 4'b0000, 12'h2AA, 10, 1'b0);  wait_idle();
      // 8E2 0x07 -> parity 1
      send(8'h07, 4'b0101, 12'hE0E, 12, 1'b0);  wait_idle();
      // 8O1 0x07 -> parity 0
      send(8'h07, 4'b0110, 12'h40E, 11, 1'b0);  wait_idle();
      // 7E1 0xFF -> 7 ones, parity 1, 10 bits
      send(8'hFF, 4'b1100, 12'h3FE, 10, 1'b0);  wait_idle();

      // back-to-back with tx_valid held: 0xA5 then 0x3C
      acc0 = accepts;
      @(negedge clk);
      tx_data = 8'hA5; data7 = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
      tx_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      e.bits = 12'h34A; e.len = 10; e.abort = 1'b0;
      q.push_back(e);
      #1 tx_data = 8'h3C;
      @(negedge clk);
      wait_ready();
      @(posedge clk);
      e.bits = 12'h278; e.len = 10; e.abort = 1'b0;
      q.push_back(e);
      #1 tx_valid = 1'b0;
      wait_idle();
      check("b2b_accepts", 32'(accepts - acc0), 2);
      check("b2b_gap", 32'(last_gap), 1);

      // mid-frame config change: current frame stays 8N1, next is 8E2
      send(8'h81, 4'b0000, 12'h302, 10, 1'b0);
      repeat (200) @(negedge clk);
      parity_en = 1'b1;
      stop2     = 1'b1;
      wait_idle();
      send(8'h81, 4'b0101, 12'hD02, 12, 1'b0);  wait_idle();

      // reset during data bit 3 of 0x33 (bit 3 = 0)
      send(8'h33, 4'b0000, 12'h000, 10, 1'b1);
      repeat (285) @(negedge clk);
      check("pre_rst_txd", 32'(txd), 0);
      check("pre_rst_busy", 32'(tx_busy), 1);
      #3 a_reset = 1'b1;
      #1;
      check("async_txd", 32'(txd), 1);
      check("async_busy", 32'(tx_busy), 0);
      check("async_ready", 32'(tx_ready), 1);
      check("async_done", 32'(tx_done), 0);
      repeat (5) @(negedge clk);
      check("hold_txd", 32'(txd), 1);
      check("hold_busy", 32'(tx_busy), 0);
      a_reset = 1'b0;
      repeat (3) @(negedge clk);
      send(8'h5A, 4'b0000, 12'h2B4, 10, 1'b0);  wait_idle();

      check("queue_empty", 32'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      failures = failures + 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the 16x-oversampled `b_tick` strobe from the baud generator and serialises bytes popped from the TX FIFO onto `txd`. It sits between the TX FIFO read side and the pad. It supports 7/8 data bits, optional even/odd parity and 1/2 stop bits, all configured from the AXI-Lite control register. It accepts one character per valid/ready handshake.

## Interface
- `OVERSAMPLE`, 16: `b_tick` pulses per bit period; must be ≥ 2.
- `clk`  in  1  system clock.
- `a_reset`  in  1  asynchronous, active-high reset.
- `b_tick`  in  1  one-cycle strobe from the baud generator, `OVERSAMPLE` per bit.
- `tx_data`  in  8  character to send; bit 0 is sent first.
- `tx_valid`  in  1  FIFO has data (not empty).
- `tx_ready`  out  1  transmitter can accept; doubles as the FIFO pop.
- `data7`  in  1  0 = 8 data bits, 1 = 7 data bits (`tx_data[7]` ignored).
- `parity_en`  in  1  insert a parity bit.
- `parity_odd`  in  1  0 = even parity, 1 = odd parity.
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `txd`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse at end of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_ready` = 1 (combinational from state); `txd` = 1.
  - On `tx_valid & tx_ready`: latch `tx_data`, `data7`, `parity_en`, `parity_odd` and `stop2`; clear the tick and bit counters; go to START.
- Config inputs changing mid-frame have no effect on the frame in progress.
- START: `txd` = 0 for one bit period, then DATA.
- DATA: shift out LSB first. 8 bits, or 7 bits when `data7` is latched. Then go to PARITY if `parity_en`, else STOP.
- PARITY: bit = XOR of the transmitted data bits, inverted when `parity_odd` is set. Then STOP.
- STOP: `txd` = 1 for 1 or 2 bit periods.
  - At the end: `tx_done` = 1 for one cycle, go to IDLE.
- Bit period: the tick counter (4 bits for the default) increments on each `b_tick`. A bit ends on the `b_tick` where the counter = `OVERSAMPLE-1`; the counter then wraps to 0. Cycles without `b_tick` hold all state.
- `tx_busy` = (state != IDLE).
- Reset (asynchronous, any state): state = IDLE, `txd` = 1, `tx_busy` = 0, `tx_done` = 0, `tx_ready` = 1. A partially sent frame is abandoned, and its FIFO entry is already consumed. Reset values hold while `a_reset` is high.

## Timing
- Handshake:
  - Transfer occurs on the rising edge where `tx_valid & tx_ready`.
  - `tx_ready` falls in the next cycle.
  - `tx_valid` may drop at any time without harm.
- `txd` goes low the cycle after the accept edge (registered output).
- The start bit is not aligned to a tick: its length is `OVERSAMPLE` `b_tick` edges counted from entry. Every later bit is exactly `OVERSAMPLE` tick intervals.
- `tx_done` is asserted in the same cycle as the return to IDLE. `tx_ready` is high in that cycle.
- Back-to-back frames: the next accept can occur at the first edge after `tx_done`. The idle gap between frames is therefore 1 clock, plus the start-bit alignment.
- Frame length in bits = 1 + (8 or 7) + `parity_en` + (1 or 2). The range is 9 to 12 bits.

## Structure
- `uart_pkg` holds:
  - the `tx_state_t` enum (IDLE/START/DATA/PARITY/STOP);
  - the `OVERSAMPLE_DEFAULT` = 16 constant;
  - a `uart_cfg_t` packed struct {`data7`, `parity_en`, `parity_odd`, `stop2`}, shared with the future `uart_rx`.
- No sub-module is needed. Build it as a single FSM with a tick counter, a bit counter, a shift register and a running parity register.

## Test plan
Use `b_tick` every 4 clocks, `OVERSAMPLE` = 16, so 1 bit = 64 clocks.
- 8N1, `tx_data` = 0x55:
  - `txd` = 0,1,0,1,0,1,0,1,0,1, then 1.
  - Each bit lasts 64 clocks; the start bit lasts 61–64.
  - `tx_done` arrives about 640 clocks after accept.
- 8E2, 0x07:
  - Data 1,1,1,0,0,0,0,0, then parity 1, then 2 stop bits of 128 clocks total.
  - The same frame in 8O1 gives parity 0.
- 7E1, 0xFF:
  - Only 7 ones are sent; `tx_data[7]` is ignored.
  - Parity bit = 1; the frame is 10 bits.
- `tx_valid` held high with FIFO data 0xA5 then 0x3C:
  - `tx_ready` pulses exactly once per frame.
  - The second start bit begins 1 clock after `tx_done` plus tick alignment.
  - No byte is lost or duplicated.
- Change `parity_en` and `stop2` mid-frame: the current frame keeps its latched format, and the next frame uses the new one.
- Assert `a_reset` during DATA bit 3:
  - `txd` = 1 and `tx_busy` = 0 immediately (asynchronous); `tx_ready` = 1.
  - After release, the next accepted byte is transmitted cleanly.
